pll_lock_ctrl: RTL and testbench
================================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: refclk cycles pll_rst is held high per sequencing attempt (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: refclk cycles allowed for lock after pll_rst release (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before ready.
REQ-004 SHALL have parameter MAX_RETRY, default 3: re-sequencing attempts after the first timeout before declaring failure (1..3).
REQ-005 SHALL have port refclk, input, 1: free-running 50 MHz reference clock, sole clock of the block.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1: single-cycle synchronous request to re-sequence the PLL.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driven to the PLL.
REQ-010 SHALL have port pll_ready, output, 1: high while the PLL output clock is qualified for use.
REQ-011 SHALL have port lock_err, output, 1: sticky failure flag, all retries exhausted.
REQ-012 SHALL have port retry_cnt, output, 2: timeouts in the current sequence.
REQ-013 SHALL have port lost_lock_cnt, output, 8: lock losses seen in READY, saturating at 255.
REQ-014 SHALL have port state, output, 3: current state encoding (RESET=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4).

Function
REQ-015 SHALL synchronize pll_locked through two refclk flops (reset value 0); all decisions use the synchronized value locked_s, 2-cycle latency.
REQ-016 SHALL enter RESET after rst_n deassertion with pll_rst=1; pll_rst high exactly RST_CYCLES cycles, then WAIT_LOCK with pll_rst=0.
REQ-017 SHALL in WAIT_LOCK count cycles from 0; locked_s=1 -> STABLE with stable counter cleared.
REQ-018 SHALL, if WAIT_LOCK count reaches LOCK_TIMEOUT-1 with locked_s=0, go to RESET with retry_cnt+1 when retry_cnt<MAX_RETRY, else to FAIL.
REQ-019 SHALL in STABLE count consecutive locked_s=1 cycles; on reaching STABLE_CYCLES go to READY; locked_s=0 -> WAIT_LOCK with timeout counter cleared (retry_cnt unchanged).
REQ-020 SHALL drive pll_ready=1 only in READY, registered, first high cycle = first READY cycle.
REQ-021 SHALL in READY, on locked_s=0: pll_ready=0 next cycle, lost_lock_cnt+1 (saturate 255), retry_cnt cleared, go to RESET.
REQ-022 SHALL in FAIL hold pll_rst=1, pll_ready=0, lock_err=1 until relock_req or reset.
REQ-023 SHALL on relock_req in READY or FAIL go to RESET, clear retry_cnt and lock_err; relock_req in RESET/WAIT_LOCK/STABLE ignored.
REQ-024 SHALL give relock_req priority over simultaneous locked_s=0 in READY (one RESET entry, lost_lock_cnt not incremented).
REQ-025 SHALL hold pll_rst=1 in RESET and FAIL, 0 in all other states.

Reset
REQ-026 SHALL on rst_n=0 asynchronously set: state=RESET, pll_rst=1, pll_ready=0, lock_err=0, retry_cnt=0, lost_lock_cnt=0, all counters and synchronizer flops 0.
REQ-027 SHALL on reset mid-operation (any state) abort immediately and restart the full sequence from RESET on release.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-028 SHALL cover nominal: release rst_n, raise pll_locked 5 cycles after pll_rst falls -> pll_rst high 4 cycles, pll_ready rises after 2 sync + 8 stable cycles, retry_cnt=0.
REQ-029 SHALL cover timeout/fail: pll_locked held 0 -> three 4-cycle pll_rst pulses separated by 20-cycle waits, retry_cnt 1 then 2, then FAIL with lock_err=1, pll_rst=1, state=4.
REQ-030 SHALL cover glitch in STABLE: drop pll_locked for 3 cycles after 5 stable cycles -> back to WAIT_LOCK, pll_ready stays 0, stable count restarts, READY reached 8 cycles after lock returns.
REQ-031 SHALL cover loss in READY: drop pll_locked -> pll_ready falls 3 cycles later, lost_lock_cnt=1, full re-sequence; repeat 256 losses -> lost_lock_cnt stays 255.
REQ-032 SHALL cover relock from FAIL and relock_req coincident with lock loss in READY -> RESET, lock_err=0, retry_cnt=0, lost_lock_cnt unchanged.
REQ-033 SHALL cover rst_n asserted in STABLE and in READY -> all outputs at REQ-026 values asynchronously, sequence restarts on release.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// pll_lock_ctrl
//
// Sequences an external PLL out of reset and qualifies its output clock.
// The PLL reset is pulsed for RST_CYCLES refclk cycles. The controller then
// waits up to LOCK_TIMEOUT cycles for lock. Lock must then hold for
// STABLE_CYCLES consecutive cycles before pll_ready is raised. A lock timeout
// restarts the sequence up to MAX_RETRY times. After that the block parks in
// FAIL with the PLL held in reset. A lock loss while ready is counted and
// triggers a full re-sequence.
//
// Parameters
//   RST_CYCLES    : cycles pll_rst is held high per attempt (>= 2)
//   LOCK_TIMEOUT  : cycles allowed for lock after pll_rst release (>= 2)
//   STABLE_CYCLES : consecutive locked cycles required before ready (>= 1)
//   MAX_RETRY     : re-sequencing attempts after the first timeout (1..3)
//
// Ports
//   refclk        in   free-running reference clock, only clock of the block
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   relock_req    in   single-cycle request to re-sequence (READY/FAIL only)
//   pll_rst       out  active-high reset to the PLL
//   pll_ready     out  PLL output clock qualified for use
//   lock_err      out  sticky failure flag, all retries exhausted
//   retry_cnt     out  timeouts seen in the current sequence
//   lost_lock_cnt out  lock losses seen in READY, saturating at 255
//   state         out  current state (RESET=0 WAIT_LOCK=1 STABLE=2 READY=3
//                      FAIL=4)
//
// Handshake: relock_req has no ready/ack. It is sampled on every refclk edge.
// It acts only when the current state is READY or FAIL and is dropped silently
// otherwise.
// ---------------------------------------------------------------------------
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       lock_err,
  output logic [1:0] retry_cnt,
  output logic [7:0] lost_lock_cnt,
  output logic [2:0] state
);

  // One shared phase counter serves all timed states, so it must cover the
  // longest of the three intervals.
  localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // -------------------------------------------------------------------------
  // Lock synchronizer. pll_locked comes from another clock domain.
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_rst_q, pll_ready_q, lock_err_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      lost_q      <= 8'd0;
      pll_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      lock_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      // Outputs are registered from the next state so that each one changes
      // on the same edge as the state it belongs to.
      pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      pll_ready_q <= (state_d == ST_READY);
      lock_err_q  <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            state_d = ST_RESET;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE: begin
        // A drop in lock restarts the wait without consuming a retry.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_READY: begin
        // An explicit relock wins over a coincident lock loss. Only one
        // re-sequence happens and the loss is not counted.
        if (relock_req) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          retry_d = 2'd0;
        end else if (!locked_s) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          retry_d = 2'd0;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end
      end

      ST_FAIL: begin
        if (relock_req) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          retry_d = 2'd0;
        end
      end

      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
        retry_d = 2'd0;
      end
    endcase
  end

  assign pll_rst       = pll_rst_q;
  assign pll_ready     = pll_ready_q;
  assign lock_err      = lock_err_q;
  assign retry_cnt     = retry_q;
  assign lost_lock_cnt = lost_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Bench for pll_lock_ctrl with short timing parameters. A phase/timestamp
// reference model predicts every output after each refclk edge. A compare
// process checks the DUT against it on every falling edge. Directed scenarios
// add literal timing and value checks. Randomized lock waveforms, relock
// pulses and reset pulses follow.
// ---------------------------------------------------------------------------
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_READY  = 3;
  localparam int P_FAIL   = 4;

  // ---------------- clock / reset ----------------
  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       pll_ready;
  logic       lock_err;
  logic [1:0] retry_cnt;
  logic [7:0] lost_lock_cnt;
  logic [2:0] state;

  initial forever #5 refclk = ~refclk;

  pll_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .pll_ready    (pll_ready),
    .lock_err     (lock_err),
    .retry_cnt    (retry_cnt),
    .lost_lock_cnt(lost_lock_cnt),
    .state        (state)
  );

  int tests = 0;
  int fails = 0;

  // Packed output vector: {state[2:0], pll_rst, pll_ready, lock_err, retry[1:0], lost[7:0]}
  function automatic logic [15:0] pack_out(input logic [2:0] s, input logic r, input logic rdy,
                                           input logic e, input logic [1:0] rt, input logic [7:0] l);
    return {s, r, rdy, e, rt, l};
  endfunction

  logic [15:0] reset_vec;
  assign reset_vec = pack_out(3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);

  task automatic check_vec(input string nm, input logic [15:0] exp);
    logic [15:0] got;
    got = pack_out(state, pll_rst, pll_ready, lock_err, retry_cnt, lost_lock_cnt);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got state=%0d rst=%b rdy=%b err=%b retry=%0d lost=%0d, expected state=%0d rst=%b rdy=%b err=%b retry=%0d lost=%0d",
               nm, $time, got[15:13], got[12], got[11], got[10], got[9:8], got[7:0],
               exp[15:13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic check_lit(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is tracked as an edge count. Each phase records the edge at which it
  // began. Its duration rules are then simple differences. The synchronizer is
  // a two-deep delay line of input samples.
  int     m_ph    = P_RESET;
  int     m_retry = 0;
  int     m_lost  = 0;
  longint m_cyc   = 0;
  longint m_t0    = 0;
  bit     m_hist[$] = '{1'b0, 1'b0};
  logic [15:0] exp_q[$];

  function automatic void enter(input int p);
    m_ph = p;
    m_t0 = m_cyc;
  endfunction

  function automatic logic [15:0] model_vec();
    return pack_out(3'(m_ph), (m_ph == P_RESET) || (m_ph == P_FAIL), m_ph == P_READY,
                    m_ph == P_FAIL, 2'(m_retry), 8'(m_lost));
  endfunction

  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      m_ph = P_RESET; m_retry = 0; m_lost = 0; m_cyc = 0; m_t0 = 0;
      m_hist = '{1'b0, 1'b0};
      exp_q.delete();
    end else begin
      bit     ls;
      longint n;
      ls = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(pll_locked);
      m_cyc++;
      n = m_cyc - m_t0;
      case (m_ph)
        P_RESET:  if (n == RST_CYCLES) enter(P_WAIT);
        P_WAIT: begin
          if (ls) enter(P_STABLE);
          else if (n == LOCK_TIMEOUT) begin
            if (m_retry < MAX_RETRY) begin m_retry++; enter(P_RESET); end
            else enter(P_FAIL);
          end
        end
        P_STABLE: begin
          if (!ls) enter(P_WAIT);
          else if (n == STABLE_CYCLES) enter(P_READY);
        end
        P_READY: begin
          if (relock_req) begin m_retry = 0; enter(P_RESET); end
          else if (!ls) begin
            if (m_lost < 255) m_lost++;
            m_retry = 0;
            enter(P_RESET);
          end
        end
        default: if (relock_req) begin m_retry = 0; enter(P_RESET); end
      endcase
      exp_q.push_back(model_vec());
    end
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    logic [15:0] exp;
    @(negedge refclk);
    if (!rst_n || exp_q.size() == 0) exp = reset_vec;
    else exp = exp_q.pop_front();
    check_vec("cycle", exp);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k = 0;
    while (state !== s && k < budget) begin
      @(negedge refclk);
      k++;
    end
    if (state !== s) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for state %0d, state=%0d", nm, s, state);
    end
  endtask

  // Counts rising edges until pll_rst drops (sel=0) or pll_ready rises (sel=1)
  // or pll_ready drops (sel=2) or state reaches FAIL (sel=3).
  task automatic count_edges(input int sel, input int budget, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge refclk);
      #1;
      n++;
      case (sel)
        0: done = !pll_rst;
        1: done = pll_ready;
        2: done = !pll_ready;
        default: done = (state == 3'd4);
      endcase
    end
  endtask

  task automatic pulse_reset(input int low_cycles, input string nm);
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1 check_vec(nm, reset_vec);
    repeat (low_cycles) @(negedge refclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_relock();
    @(negedge refclk);
    #1 relock_req = 1'b1;
    @(negedge refclk);
    #1 relock_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge refclk);
    check_vec("reset_values", reset_vec);

    // Nominal bring-up.
    #1 rst_n = 1'b1;
    count_edges(0, 50, n);
    check_lit("nominal_rst_width", n, 4);
    repeat (5) @(negedge refclk);
    #1 pll_locked = 1'b1;
    // 2 synchronizer edges + 1 detect edge + 8 stable edges
    count_edges(1, 60, n);
    check_lit("nominal_ready_latency", n, 11);
    check_lit("nominal_retry", int'(retry_cnt), 0);

    // Loss in READY.
    @(negedge refclk);
    #1 pll_locked = 1'b0;
    count_edges(2, 20, n);
    check_lit("loss_ready_fall", n, 3);
    check_lit("loss_lost_cnt", int'(lost_lock_cnt), 1);
    check_lit("loss_state_reset", int'(state), 0);

    // Glitch in STABLE.
    #1 pll_locked = 1'b1;
    wait_state(3'd2, 100, "glitch_reach_stable");
    repeat (4) @(negedge refclk);
    #1 pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    #1 pll_locked = 1'b1;
    count_edges(1, 60, n);
    check_lit("glitch_ready_latency", n, 11);

    // relock_req coincident with lock loss: both reach the sequencer on the
    // same edge.
    @(negedge refclk);
    #1 pll_locked = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    #1 relock_req = 1'b1;
    @(negedge refclk);
    #1 relock_req = 1'b0;
    check_lit("coincide_state", int'(state), 0);
    check_lit("coincide_lost_kept", int'(lost_lock_cnt), 1);

    // Timeout path into FAIL with lock held low: 3 x (4 reset + 20 wait).
    count_edges(3, 200, n);
    check_lit("fail_time", n, 72);
    check_lit("fail_retry", int'(retry_cnt), 2);
    check_lit("fail_err", int'(lock_err), 1);
    check_lit("fail_rst", int'(pll_rst), 1);
    repeat (5) @(negedge refclk);
    check_lit("fail_hold", int'(state), 4);

    // Relock out of FAIL.
    pulse_relock();
    check_lit("relock_fail_state", int'(state), 0);
    check_lit("relock_fail_err", int'(lock_err), 0);
    check_lit("relock_fail_retry", int'(retry_cnt), 0);

    // Reset asserted in STABLE and in READY.
    #1 pll_locked = 1'b1;
    wait_state(3'd2, 100, "rst_reach_stable");
    pulse_reset(3, "async_rst_stable");
    wait_state(3'd3, 100, "rst_reach_ready");
    pulse_reset(2, "async_rst_ready");
    wait_state(3'd3, 100, "rst_resequence");

    // Randomized lock waveforms, relock pulses and occasional resets.
    for (int i = 0; i < 150; i++) begin
      int  hold;
      bit  v;
      hold = $urandom_range(1, 40);
      v = ($urandom_range(0, 3) != 0);
      repeat (hold) begin
        @(negedge refclk);
        #1 pll_locked = v;
        relock_req = ($urandom_range(0, 30) == 0);
      end
      if ($urandom_range(0, 24) == 0) pulse_reset($urandom_range(1, 4), "async_rst_rand");
    end
    @(negedge refclk);
    #1 relock_req = 1'b0;
    pulse_reset(2, "async_rst_pre_sat");

    // Drive enough READY losses to saturate the loss counter.
    for (int i = 0; i < 260; i++) begin
      #1 pll_locked = 1'b1;
      wait_state(3'd3, 100, "sat_reach_ready");
      @(negedge refclk);
      #1 pll_locked = 1'b0;
      wait_state(3'd0, 20, "sat_reach_reset");
    end
    check_lit("lost_saturate", int'(lost_lock_cnt), 255);

    repeat (3) @(negedge refclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
